// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB state encoding, default widths and command record
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    // Encoding is shared with apb_comp, so the values are fixed.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

    typedef struct packed {
        logic                    write;
        logic [APB_ADDR_W-1:0]   addr;
        logic [APB_DATA_W-1:0]   wdata;
        logic [APB_DATA_W/8-1:0] strb;
        logic [2:0]              prot;
    } apb_cmd_t;

endpackage

// File: rtl/apb_requester.sv
// rtl/apb_requester.sv - APB5 requester: single-beat commands to SETUP/ACCESS transfers
//
// Ports:
//   pclk, preset_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake (write, addr, wdata, strb, prot)
//   rsp_valid/rsp_rdata/rsp_err    one-cycle completion pulse, read data, error
//   psel/penable/pwrite/paddr/pwdata/pstrb/pprot   APB requester outputs (registered)
//   prdata/pready/pslverr          APB completer inputs
//
// Build option: APB_TIMEOUT_EN adds an 8-bit ACCESS wait counter that aborts a
// transfer after TIMEOUT_CYCLES cycles of pready low and reports it as an error.
module apb_requester
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                pclk,
    input  logic                preset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    input  logic [2:0]          cmd_prot,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    output logic [2:0]          pprot,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pready,
    input  logic                pslverr
);

    localparam int STRB_W = DATA_W / 8;

    apb_state_e          state_q, state_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]   pstrb_q, pstrb_d;
    logic [2:0]          pprot_q, pprot_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                cmd_fire;

`ifdef APB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]          wait_cnt_q, wait_cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        pprot_d     = pprot_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif

        // Accepting in the completing ACCESS cycle is what lets psel stay high
        // across back-to-back transfers.
        cmd_ready = (state_q == IDLE) || ((state_q == ACCESS) && pready);
        cmd_fire  = cmd_valid && cmd_ready;

        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
`ifdef APB_TIMEOUT_EN
                wait_cnt_d = 8'd0;
`endif
            end
            ACCESS: begin
                if (pready) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pslverr;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                    state_d     = cmd_fire ? SETUP : IDLE;
                end
`ifdef APB_TIMEOUT_EN
                else if (wait_cnt_q == TIMEOUT_LAST) begin
                    // Abort: report as an error with no data.
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cmd_fire) begin
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_write ? cmd_wdata : '0;
            pstrb_d  = cmd_write ? cmd_strb : '0;
            pprot_d  = cmd_prot;
        end

        // Bus strobes are registered copies of the next state.
        psel_d    = (state_d != IDLE);
        penable_d = (state_d == ACCESS);
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            pprot_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            pprot_q     <= pprot_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef APB_TIMEOUT_EN
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            wait_cnt_q <= 8'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pstrb     = pstrb_q;
    assign pprot     = pprot_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_requester.sv
// tb/tb_apb_requester.sv - directed self-checking bench for apb_requester with a behavioural completer
module tb_apb_requester;

    logic        pclk = 1'b0;
    logic        preset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready, pslverr;

    int total = 0;
    int bad   = 0;

    always #5 pclk = ~pclk;

    apb_requester dut (
        .pclk(pclk), .preset_n(preset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    // Completer: mem word at address a initially holds a; 0x80+ is non-secure.
    logic [31:0] mem [0:63];
    logic        mem_init;
    int          wait_req;
    logic        stuck;
    int          acc_cnt;
    logic        cpl_err;

    always_comb begin
        cpl_err = (paddr[1:0] != 2'b00) || ((paddr >= 32'h80) && !pprot[1]);
        pready  = !stuck && (acc_cnt >= wait_req);
        pslverr = psel && penable && cpl_err;
        prdata  = cpl_err ? 32'h0 : mem[paddr[7:2]];
    end

    always @(posedge pclk) begin
        acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'(i * 4);
        end else if (psel && penable && pready && pwrite && !cpl_err) begin
            for (int b = 0; b < 4; b++)
                if (pstrb[b]) mem[paddr[7:2]][b*8 +: 8] <= pwdata[b*8 +: 8];
        end
    end

    // Bus monitor: cycle counts, stability of SETUP-captured fields, psel drops, responses.
    int          setup_cnt = 0, access_cnt = 0, stab_cnt = 0, drop_cnt = 0, rsp_cnt = 0;
    logic        prev_psel = 1'b0;
    logic [71:0] cap;
    logic [31:0] rsp_q[$];

    always @(negedge pclk) begin
        if (psel && !penable) begin
            setup_cnt = setup_cnt + 1;
            cap = {paddr, pwdata, pstrb, pprot, pwrite};
        end
        if (psel && penable) begin
            access_cnt = access_cnt + 1;
            if (cap !== {paddr, pwdata, pstrb, pprot, pwrite}) stab_cnt = stab_cnt + 1;
        end
        if (prev_psel && !psel) drop_cnt = drop_cnt + 1;
        prev_psel = psel;
        if (rsp_valid) begin
            rsp_q.push_back(rsp_rdata);
            rsp_cnt = rsp_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge pclk);
        #1;
    endtask

    // One command; waits for its response and checks latency, data, error and bus shape.
    task automatic xfer(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] p, input logic [31:0] exp_d,
                        input logic exp_e, input int exp_lat, input int exp_acc);
        int n;
        int s0, a0, st0;
        s0 = setup_cnt; a0 = access_cnt; st0 = stab_cnt;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_prot = p;
        n = 0;
        while (!cmd_ready && n < 50) begin step(); n++; end
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 60) begin step(); n++; end
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk({tag, "_rdata"}, rsp_rdata, exp_d);
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
        chk({tag, "_setup"}, 32'(setup_cnt - s0), 32'd1);
        chk({tag, "_access"}, 32'(access_cnt - a0), 32'(exp_acc));
        chk({tag, "_stable"}, 32'(stab_cnt - st0), 32'd0);
        step();
        chk({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int n;
        int d0, s0, r0;
        preset_n = 1'b0; mem_init = 1'b1; wait_req = 0; stuck = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
        step(); step();
        mem_init = 1'b0;

        // Reset state
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_bus", {pwdata[27:0], pstrb}, 32'd0);
        preset_n = 1'b1;
        step();
        chk("idle_ready", 32'(cmd_ready), 32'd1);

        // 1: write then read back
        xfer("t1w", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 32'h0, 1'b0, 3, 1);
        xfer("t1r", 1'b0, 32'h10, 32'h0, 4'hF, 3'b000, 32'hDEADBEEF, 1'b0, 3, 1);

        // 2: partial strobes
        xfer("t2w", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 3'b000, 32'h0, 1'b0, 3, 1);
        xfer("t2r", 1'b0, 32'h20, 32'h0, 4'hF, 3'b000, 32'h00BB00DD, 1'b0, 3, 1);

        // 3: errors (misaligned, secure access to non-secure region), then an ok read
        xfer("t3mis", 1'b0, 32'h13, 32'h0, 4'h0, 3'b000, 32'h0, 1'b0 | 1'b1, 3, 1);
        xfer("t3sec", 1'b0, 32'h84, 32'h0, 4'h0, 3'b000, 32'h0, 1'b1, 3, 1);
        xfer("t3ns", 1'b0, 32'h84, 32'h0, 4'h0, 3'b010, 32'h84, 1'b0, 3, 1);

        // 4: three back-to-back reads with cmd_valid held high
        d0 = drop_cnt; s0 = setup_cnt; r0 = rsp_cnt;
        rsp_q.delete();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_prot = 3'b000; cmd_strb = 4'h0;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!cmd_ready && n < 20) begin step(); n++; end
            step();
            if (i < 2) cmd_addr = 32'((i + 1) * 4);
            else cmd_valid = 1'b0;
        end
        n = 0;
        while ((rsp_cnt - r0) < 3 && n < 20) begin step(); n++; end
        step();
        chk("t4_rsp_cnt", 32'(rsp_cnt - r0), 32'd3);
        for (int i = 0; i < 3; i++)
            chk("t4_rdata", (i < rsp_q.size()) ? rsp_q[i] : 32'hFFFF_FFFF, 32'(i * 4));
        chk("t4_setups", 32'(setup_cnt - s0), 32'd3);
        chk("t4_psel_drops", 32'(drop_cnt - d0), 32'd1);

        // 5: three wait states
        wait_req = 3;
        xfer("t5w", 1'b1, 32'h30, 32'h12345678, 4'hF, 3'b001, 32'h0, 1'b0, 6, 4);
        xfer("t5r", 1'b0, 32'h30, 32'h0, 4'hF, 3'b001, 32'h12345678, 1'b0, 6, 4);
        wait_req = 0;

`ifdef APB_TIMEOUT_EN
        stuck = 1'b1;
        xfer("t5to", 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 32'h0, 1'b1, 18, 16);
        chk("t5to_psel", 32'(psel), 32'd0);
        stuck = 1'b0;
`endif

        // 6: reset during ACCESS
        wait_req = 5;
        r0 = rsp_cnt;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10; cmd_prot = 3'b000;
        step();
        cmd_valid = 1'b0;
        step(); step();
        chk("t6_in_access", 32'(penable), 32'd1);
        preset_n = 1'b0;
        #1;
        chk("t6_psel_async", 32'(psel), 32'd0);
        chk("t6_penable_async", 32'(penable), 32'd0);
        step(); step();
        preset_n = 1'b1;
        step(); step();
        chk("t6_no_rsp", 32'(rsp_cnt - r0), 32'd0);
        wait_req = 0;
        xfer("t6r", 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 32'hDEADBEEF, 1'b0, 3, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
